local_max_5x5: RTL
==================

Name: local_max_5x5

Overview:
- Streaming feature stage that sits directly downstream of the downsampler and directly upstream of the upsampler.
- Consumes the downsampled 8-bit luma raster and builds a 5x5 neighbourhood from four line buffers.
- For each pixel, flags whether the window centre is a strict local maximum above a threshold.
- Emits one output pixel per input pixel (8'hFF = feature, 8'h00 = none), plus a per-frame feature count.

Parameters:
- WIDTH, 320, active pixels per row of the downsampled image.
- HEIGHT, 240, active rows per frame.
- THRESH, 8'd32, centre must be strictly greater than this value.
- CNT_W, 16, width of the feature counter.

Ports:
- clock  in  1  single clock, shared with the downsampler output domain.
- reset  in  1  synchronous, active-high.
- din  in  8  input pixel.
- validin  in  1  din carries a pixel this cycle.
- blanking_in  in  1  vertical blanking between frames.
- dout  out  8  8'hFF if the window centre is a feature, else 8'h00.
- validout  out  1  dout valid.
- blanking_out  out  1  blanking_in delayed to align with dout.
- feature_count  out  CNT_W  features in the last completed frame.

Behaviour:
- Reset:
  - dout, validout, blanking_out and feature_count go to 0.
  - Row/column counters, running count and 5x5 window go to 0.
  - Line-buffer RAM contents are not cleared; border masking hides stale data.
- Pixel acceptance:
  - A pixel is accepted when validin=1 and blanking_in=0.
  - validin=1 with blanking_in=1 drops the pixel; no output is produced.
- Counters (col 0..WIDTH-1, row 0..HEIGHT-1):
  - col increments on each accepted pixel; at WIDTH-1 it wraps to 0 and row increments.
  - row wraps to 0 after HEIGHT-1.
  - Any cycle with blanking_in=1 forces col=row=0, so the next frame realigns.
- Line buffers:
  - Four WIDTH x 8 buffers, addressed by col, read-before-write.
  - On each accepted pixel, buffer k outputs row r-k-1 at this column and stores row r-k. Buffer 0 stores din.
- Window:
  - A 5x5 register array; each accepted pixel shifts in a new column {din, lb0..lb3}.
  - Window centre = pixel (r-2, c-2), where (r,c) is the accepted pixel.
- Pipeline (2 stages, latency 2):
  - Stage 1 (edge k, the acceptance edge): window shift; register border flag = (r<4 || c<4).
  - Stage 2 (edge k+1): register dout = (!border && centre > THRESH && centre > each of the 24 neighbours) ? 8'hFF : 8'h00. validout is registered from the stage-1 valid.
  - dout/validout for a pixel accepted at edge k are visible after edge k+1 and held until edge k+2.
  - validout is asserted for exactly one cycle per accepted pixel.
  - blanking_out is blanking_in delayed 2 cycles.
- Comparisons are unsigned, strict `>`. A tie with any neighbour is not a feature.
- Border:
  - Output positions whose centre lies in row/col 0..1 output 8'h00.
  - The window never wraps across rows.
  - Centres in the last two rows/cols of a frame are never output. The output raster is shifted by (+2,+2); the upsampler tolerates this.
- Count:
  - The running counter increments on each stage-2 output with dout=8'hFF, saturating at all-ones.
  - On the rising edge of blanking_out: feature_count <= running count (including a same-cycle increment); running count <= 0.
- Mid-frame behaviour:
  - Reset mid-frame discards all state; the first accepted pixel after reset is treated as (0,0).
  - Blanking mid-frame realigns the counters and latches a partial count.
- Throughput: one pixel per clock; no backpressure.

Decomposition:
- Shared package (feature_pkg):
  - PIX_W=8
  - FEATURE_ON=8'hFF, FEATURE_OFF=8'h00
  - default DS_WIDTH=320, DS_HEIGHT=240
  - WIN=5
- One sub-module: line_buffer (parameter DEPTH; synchronous read-before-write RAM with addr, we, wdata, rdata). Instantiated four times.

Test Plan (WIDTH=8, HEIGHT=8, THRESH=20 unless noted):
- Reset asserted for 3 cycles with validin toggling -> dout=0, validout=0, feature_count=0 throughout reset.
- Flat frame (all 64 pixels = 50), then 4 blanking cycles -> 64 validout pulses, all dout=00; feature_count=0.
- Background 10 with a single 200 at (4,4), then blanking -> only output #54 (0-based; input (6,6)) is FF, appearing 2 cycles after that input; feature_count=1.
- Tie: 200 at both (4,4) and (4,5), background 10 -> all dout=00; feature_count=0.
- Threshold: peak 25 at (4,4), background 10, THRESH=30 -> all 00. Same frame with THRESH=20 -> count=1.
- Realignment: blanking_in asserted after 20 pixels, then a full frame with the peak at (4,4) -> FF at output #54 of the new frame. Reset mid-frame followed by the same frame -> identical result.

Source files
------------

// File: rtl/feature_pkg.sv
// Shared constants for the downsampled-luma feature stages.
package feature_pkg;
  localparam int PIX_W     = 8;
  localparam int DS_WIDTH  = 320;
  localparam int DS_HEIGHT = 240;
  localparam int WIN       = 5;
  localparam int WIN_CTR   = WIN / 2;

  localparam logic [PIX_W-1:0] FEATURE_ON  = 8'hFF;
  localparam logic [PIX_W-1:0] FEATURE_OFF = 8'h00;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// One raster line of pixels; a read returns the pre-write contents of the addressed entry.
module line_buffer
  import feature_pkg::*;
#(
  parameter int DEPTH = DS_WIDTH,
  localparam int AW   = addr_bits(DEPTH)
) (
  input  logic             clock,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem_r [DEPTH];

  // Write port; contents are never cleared, the consumer masks stale entries
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/local_max_5x5.sv
// 5x5 strict local-maximum detector on a streaming raster, with per-frame feature count.
module local_max_5x5
  import feature_pkg::*;
#(
  parameter int               WIDTH  = DS_WIDTH,
  parameter int               HEIGHT = DS_HEIGHT,
  parameter logic [PIX_W-1:0] THRESH = 8'd32,
  parameter int               CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PIX_W-1:0] din,
  input  logic             validin,
  input  logic             blanking_in,
  output logic [PIX_W-1:0] dout,
  output logic             validout,
  output logic             blanking_out,
  output logic [CNT_W-1:0] feature_count
);

  localparam int COL_W = addr_bits(WIDTH);
  localparam int ROW_W = addr_bits(HEIGHT);

  logic             accept_s;
  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;
  logic [PIX_W-1:0] col_s [WIN];
  logic [PIX_W-1:0] win_r [WIN][WIN];
  logic             valid_s1_r;
  logic             border_s1_r;
  logic             peak_s;
  logic             hit_s;
  logic             blank_d1_r;
  logic             blank_rise_s;
  logic [CNT_W-1:0] running_r;
  logic [CNT_W-1:0] run_inc_s;

  assign accept_s = validin && !blanking_in;
  assign col_s[0] = din;

  // Buffer k holds row r-k-1 and is refilled with row r-k as it is read out
  for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
    line_buffer #(.DEPTH(WIDTH)) u_lb (
      .clock (clock),
      .addr  (col_r),
      .we    (accept_s),
      .wdata (col_s[k]),
      .rdata (col_s[k+1])
    );
  end

  // Raster position of the next accepted pixel; blanking realigns to (0,0)
  always_ff @(posedge clock) begin
    if (reset || blanking_in) begin
      col_r <= {COL_W{1'b0}};
      row_r <= {ROW_W{1'b0}};
    end else if (accept_s) begin
      if (col_r == COL_W'(WIDTH - 1)) begin
        col_r <= {COL_W{1'b0}};
        row_r <= (row_r == ROW_W'(HEIGHT - 1)) ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  // Stage 1: shift the new column into the window; win_r[i][j] is pixel (r-i, c-j)
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN; j++) begin
          win_r[i][j] <= {PIX_W{1'b0}};
        end
      end
      valid_s1_r  <= 1'b0;
      border_s1_r <= 1'b0;
    end else begin
      if (accept_s) begin
        for (int i = 0; i < WIN; i++) begin
          win_r[i][0] <= col_s[i];
          for (int j = 1; j < WIN; j++) begin
            win_r[i][j] <= win_r[i][j-1];
          end
        end
      end
      valid_s1_r  <= accept_s;
      border_s1_r <= (row_r < ROW_W'(WIN - 1)) || (col_r < COL_W'(WIN - 1));
    end
  end

  // Centre must beat the threshold and every neighbour; any tie kills it
  always_comb begin
    peak_s = !border_s1_r && (win_r[WIN_CTR][WIN_CTR] > THRESH);
    for (int i = 0; i < WIN; i++) begin
      for (int j = 0; j < WIN; j++) begin
        if (!(i == WIN_CTR && j == WIN_CTR) && (win_r[i][j] >= win_r[WIN_CTR][WIN_CTR])) begin
          peak_s = 1'b0;
        end else begin
          peak_s = peak_s;
        end
      end
    end
  end

  assign hit_s        = valid_s1_r && peak_s;
  assign blank_rise_s = blank_d1_r && !blanking_out;

  // Saturating increment of the running feature count
  always_comb begin
    if (hit_s && (running_r != {CNT_W{1'b1}})) begin
      run_inc_s = running_r + CNT_W'(1);
    end else begin
      run_inc_s = running_r;
    end
  end

  // Stage 2: registered outputs, blanking delay and frame count latch
  always_ff @(posedge clock) begin
    if (reset) begin
      dout          <= FEATURE_OFF;
      validout      <= 1'b0;
      blank_d1_r    <= 1'b0;
      blanking_out  <= 1'b0;
      running_r     <= {CNT_W{1'b0}};
      feature_count <= {CNT_W{1'b0}};
    end else begin
      dout         <= hit_s ? FEATURE_ON : FEATURE_OFF;
      validout     <= valid_s1_r;
      blank_d1_r   <= blanking_in;
      blanking_out <= blank_d1_r;
      if (blank_rise_s) begin
        feature_count <= run_inc_s;
        running_r     <= {CNT_W{1'b0}};
      end else begin
        running_r     <= run_inc_s;
      end
    end
  end

endmodule
